// File: rtl/ren_conv_engine_v2_if.sv
// Memory-side bus of the convolution engine: image/kernel read ports
// and result write port. master = engine, slave = memories.
interface ren_conv_engine_v2_if #(
   parameter int CHANNELS        = 3,
   parameter int DATA_WIDTH      = 8,
   parameter int IMG_ADDR_WIDTH  = 6,
   parameter int RSLT_ADDR_WIDTH = 6
) ();
   logic [IMG_ADDR_WIDTH-1:0]        img_addr;
   logic                             img_rd;
   logic [CHANNELS*DATA_WIDTH-1:0]   img_data;
   logic [IMG_ADDR_WIDTH-1:0]        kern_addr;
   logic [CHANNELS*DATA_WIDTH-1:0]   kern_data;
   logic [RSLT_ADDR_WIDTH-1:0]       res_addr;
   logic                             res_we;
   logic [DATA_WIDTH-1:0]            res_data;

   modport master (
      output img_addr, img_rd, kern_addr,
      output res_addr, res_we, res_data,
      input  img_data, kern_data
   );

   modport slave (
      input  img_addr, img_rd, kern_addr,
      input  res_addr, res_we, res_data,
      output img_data, kern_data
   );
endinterface

// File: rtl/ren_conv_engine_v2.sv
// 1-D multi-channel convolution engine with shift, saturation and 2:1 max pool.
// Ports: wb_clk_i/wb_rst_n_i, start/soft_rst, run config, bus (master), busy/done/ovf.
module ren_conv_engine_v2 #(
   parameter int CHANNELS        = 3,
   parameter int DATA_WIDTH      = 8,
   parameter int KERN_COL_WIDTH  = 3,
   parameter int COL_WIDTH       = 8,
   parameter int KERN_CNT_WIDTH  = 3,
   parameter int IMG_ADDR_WIDTH  = 6,
   parameter int RSLT_ADDR_WIDTH = 6,
   parameter int ACC_WIDTH       = 24
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_n_i,
   input  logic                      start,
   input  logic                      soft_rst,
   input  logic [KERN_COL_WIDTH-1:0] kern_cols,
   input  logic [COL_WIDTH-1:0]      cols,
   input  logic [KERN_CNT_WIDTH-1:0] kerns,
   input  logic [7:0]                stride,
   input  logic                      kern_addr_mode,
   input  logic [3:0]                shift,
   input  logic                      en_max_pool,
   input  logic                      en_relu_sat,
   input  logic [CHANNELS-1:0]       mask,
   ren_conv_engine_v2_if.master      bus,
   output logic                      busy,
   output logic                      done,
   output logic                      ovf
);
   localparam int IW = IMG_ADDR_WIDTH;
   localparam int RW = RSLT_ADDR_WIDTH;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_POST  = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]                state;
   logic                      start_d;
   logic [KERN_COL_WIDTH-1:0] kc_max, kc;
   logic [COL_WIDTH-1:0]      c_max, c;
   logic [KERN_CNT_WIDTH-1:0] n_max, ks;
   logic [7:0]                stride_q;
   logic                      mode_q;
   logic [3:0]                shift_q;
   logic                      pool_q, relu_q;
   logic [CHANNELS-1:0]       mask_q;
   logic                      rd_d, first_d;
   logic [ACC_WIDTH-1:0]      acc, mac, v, pa, pb;
   logic [DATA_WIDTH-1:0]     held, v8, out8;
   logic                      v_ovf, last_c, last_k;
   logic                      hold_only, step, fetch;
   logic [IW-1:0]             ia, ka;
   logic [RW-1:0]             ra, c_all, c_half;

   assign fetch = (state == S_FETCH);
   assign busy  = (state == S_FETCH) || (state == S_DRAIN) ||
                  (state == S_POST)  || (state == S_WRITE);
   assign done  = (state == S_DONE);

   // Read addresses are only driven while fetching so they idle at zero.
   assign ia = IW'(c * stride_q) + IW'(kc);
   assign ka = (IW'(ks) << (mode_q ? 3 : 2)) + IW'(kc);
   assign bus.img_rd    = fetch;
   assign bus.img_addr  = fetch ? ia : '0;
   assign bus.kern_addr = fetch ? ka : '0;

   assign c_all  = RW'(c_max) + RW'(1);
   assign c_half = RW'(c_max >> 1) + RW'(1);
   assign ra = pool_q ? RW'(ks) * c_half + RW'(c >> 1)
                      : RW'(ks) * c_all + RW'(c);

   assign last_c    = (c == c_max);
   assign last_k    = (ks == n_max);
   // Even pooled columns are only remembered, except a trailing odd one.
   assign hold_only = pool_q && !c[0] && !last_c;
   assign step      = ((state == S_POST) && hold_only) ||
                      (state == S_WRITE);

   always_comb begin
      mac = '0;
      pa  = '0;
      pb  = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         pa = ACC_WIDTH'(bus.img_data[ch*DATA_WIDTH +: DATA_WIDTH]);
         pb = ACC_WIDTH'(bus.kern_data[ch*DATA_WIDTH +: DATA_WIDTH]);
         if (mask_q[ch]) mac = mac + pa * pb;
      end
   end

   always_comb begin
      v     = acc >> shift_q;
      v_ovf = |v[ACC_WIDTH-1:DATA_WIDTH];
      v8    = (relu_q && v_ovf) ? '1 : v[DATA_WIDTH-1:0];
      out8  = (pool_q && c[0] && (held > v8)) ? held : v8;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state        <= S_IDLE;
         start_d      <= 1'b0;
         kc_max       <= '0;
         kc           <= '0;
         c_max        <= '0;
         c            <= '0;
         n_max        <= '0;
         ks           <= '0;
         stride_q     <= '0;
         mode_q       <= 1'b0;
         shift_q      <= '0;
         pool_q       <= 1'b0;
         relu_q       <= 1'b0;
         mask_q       <= '0;
         rd_d         <= 1'b0;
         first_d      <= 1'b0;
         acc          <= '0;
         held         <= '0;
         ovf          <= 1'b0;
         bus.res_we   <= 1'b0;
         bus.res_addr <= '0;
         bus.res_data <= '0;
      end else begin
         start_d <= start;
         rd_d    <= 1'b0;
         first_d <= 1'b0;
         // Read data lands one cycle after img_rd; the tag travels with it.
         if (rd_d) acc <= (first_d ? '0 : acc) + mac;
         if (soft_rst) begin
            state      <= S_IDLE;
            ovf        <= 1'b0;
            acc        <= '0;
            bus.res_we <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (start && !start_d) begin
                     kc_max   <= kern_cols;
                     c_max    <= cols;
                     n_max    <= kerns;
                     stride_q <= stride;
                     mode_q   <= kern_addr_mode;
                     shift_q  <= shift;
                     pool_q   <= en_max_pool;
                     relu_q   <= en_relu_sat;
                     mask_q   <= mask;
                     ks       <= '0;
                     c        <= '0;
                     kc       <= '0;
                     ovf      <= 1'b0;
                     state    <= S_FETCH;
                  end
               end
               S_FETCH: begin
                  rd_d    <= 1'b1;
                  first_d <= (kc == '0);
                  if (kc == kc_max) begin
                     kc    <= '0;
                     state <= S_DRAIN;
                  end else begin
                     kc <= kc + KERN_COL_WIDTH'(1);
                  end
               end
               S_DRAIN: state <= S_POST;
               S_POST: begin
                  if (v_ovf) ovf <= 1'b1;
                  if (hold_only) begin
                     held <= v8;
                  end else begin
                     bus.res_we   <= 1'b1;
                     bus.res_addr <= ra;
                     bus.res_data <= out8;
                     state        <= S_WRITE;
                  end
               end
               S_WRITE: bus.res_we <= 1'b0;
               S_DONE: if (!start) state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
            if (step) begin
               if (last_c) begin
                  c <= '0;
                  if (last_k) begin
                     state <= S_DONE;
                  end else begin
                     ks    <= ks + KERN_CNT_WIDTH'(1);
                     state <= S_FETCH;
                  end
               end else begin
                  c     <= c + COL_WIDTH'(1);
                  state <= S_FETCH;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_ren_conv_engine_v2.sv
// Scoreboard bench for ren_conv_engine_v2: directed runs push expected
// result writes; a negedge monitor pops and compares each res_we.
module tb_ren_conv_engine_v2;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       soft_rst = 1'b0;
   logic [2:0] kern_cols = '0;
   logic [7:0] cols = '0;
   logic [2:0] kerns = '0;
   logic [7:0] stride = 8'd1;
   logic       kern_addr_mode = 1'b0;
   logic [3:0] shift = '0;
   logic       en_max_pool = 1'b0;
   logic       en_relu_sat = 1'b1;
   logic [2:0] mask = 3'b111;
   logic       busy, done, ovf;

   ren_conv_engine_v2_if bus ();

   ren_conv_engine_v2 dut (
      .wb_clk_i       (clk),
      .wb_rst_n_i     (rst_n),
      .start          (start),
      .soft_rst       (soft_rst),
      .kern_cols      (kern_cols),
      .cols           (cols),
      .kerns          (kerns),
      .stride         (stride),
      .kern_addr_mode (kern_addr_mode),
      .shift          (shift),
      .en_max_pool    (en_max_pool),
      .en_relu_sat    (en_relu_sat),
      .mask           (mask),
      .bus            (bus),
      .busy           (busy),
      .done           (done),
      .ovf            (ovf)
   );

   always #5 clk = ~clk;

   logic [23:0] img_mem [64];
   logic [23:0] kern_mem [64];

   always @(posedge clk) begin
      bus.img_data  <= img_mem[bus.img_addr];
      bus.kern_data <= kern_mem[bus.kern_addr];
   end

   typedef struct packed {
      logic [5:0] a;
      logic [7:0] d;
   } exp_t;

   exp_t       exp_q [$];
   logic [5:0] addr_q [$];
   logic       rec_addr = 1'b0;
   int         checks = 0;
   int         errors = 0;

   always @(negedge clk) begin
      exp_t e;
      if (rec_addr && bus.img_rd) addr_q.push_back(bus.img_addr);
      if (bus.res_we) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%0d data=%0d",
                     bus.res_addr, bus.res_data);
         end else begin
            e = exp_q.pop_front();
            if (bus.res_addr !== e.a || bus.res_data !== e.d) begin
               errors++;
               $display("FAIL res_write got addr=%0d data=%0d expected addr=%0d data=%0d",
                        bus.res_addr, bus.res_data, e.a, e.d);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int a, input int d);
      exp_t e;
      e.a = 6'(a);
      e.d = 8'(d);
      exp_q.push_back(e);
   endtask

   task automatic cfg(input int kc, input int c, input int k,
                      input int str, input int md, input int sh,
                      input int pl, input int rl, input int mk);
      kern_cols      = 3'(kc);
      cols           = 8'(c);
      kerns          = 3'(k);
      stride         = 8'(str);
      kern_addr_mode = 1'(md);
      shift          = 4'(sh);
      en_max_pool    = 1'(pl);
      en_relu_sat    = 1'(rl);
      mask           = 3'(mk);
   endtask

   // Start edge, then wait (bounded) for done; start stays high.
   task automatic launch_wait(input int exp_cyc);
      int n;
      start = 1'b1;
      @(posedge clk);
      #1;
      n = 0;
      while (!done && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("done_reached", done, 1);
      if (exp_cyc >= 0) chk("done_latency", n, exp_cyc);
      chk("busy_in_done", busy, 0);
      chk("pending_writes", exp_q.size(), 0);
   endtask

   task automatic run(input int exp_cyc);
      launch_wait(exp_cyc);
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_after_done", done, 0);
   endtask

   task automatic setup_t1();
      for (int i = 0; i < 64; i++) begin
         img_mem[i]  = 24'h010101;
         kern_mem[i] = 24'h010101;
      end
      cfg(2, 3, 0, 1, 0, 0, 0, 1, 7);
   endtask

   task automatic t1_full();
      setup_t1();
      for (int i = 0; i < 4; i++) push(i, 9);
      run(24);
      chk("t1_ovf", ovf, 0);
   endtask

   task automatic abort_prep();
      setup_t1();
      push(0, 9);
      start = 1'b1;
      @(posedge clk);
      #1;
      repeat (7) @(posedge clk);
      #1;
      chk("abort_busy_before", busy, 1);
   endtask

   task automatic abort_after();
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_res_we", bus.res_we, 0);
      chk("abort_img_rd", bus.img_rd, 0);
      start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("abort_still_idle", busy, 0);
      chk("abort_pending", exp_q.size(), 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_res_we", bus.res_we, 0);
      chk("rst_img_rd", bus.img_rd, 0);
      chk("rst_img_addr", bus.img_addr, 0);
      chk("rst_res_addr", bus.res_addr, 0);
      chk("rst_res_data", bus.res_data, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      t1_full();

      for (int i = 0; i < 64; i++) begin
         img_mem[i]  = 24'hFFFFFF;
         kern_mem[i] = 24'hFFFFFF;
      end
      cfg(0, 0, 0, 1, 0, 0, 0, 1, 7);
      push(0, 255);
      run(4);
      chk("sat_ovf", ovf, 1);
      cfg(0, 0, 0, 1, 0, 0, 0, 0, 7);
      push(0, 3);
      run(4);
      chk("wrap_ovf", ovf, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("ovf_sticky_idle", ovf, 1);

      t1_full();

      for (int i = 0; i < 64; i++) begin
         img_mem[i]  = 24'hFFFFFF;
         kern_mem[i] = 24'hFFFFFF;
      end
      cfg(0, 0, 0, 1, 0, 0, 0, 1, 7);
      push(0, 255);
      launch_wait(4);
      soft_rst = 1'b1;
      @(posedge clk);
      #1;
      soft_rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("held_start_no_relaunch", busy, 0);
      chk("soft_rst_done", done, 0);
      chk("soft_rst_ovf", ovf, 0);
      start = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 64; i++) begin
         img_mem[i]  = {8'd5, 8'd5, 8'(i)};
         kern_mem[i] = 24'h010101;
      end
      cfg(1, 3, 0, 1, 0, 0, 1, 1, 1);
      push(0, 3);
      push(1, 7);
      run(-1);

      for (int i = 0; i < 64; i++) begin
         img_mem[i]  = {16'd0, 8'(i)};
         kern_mem[i] = 24'd0;
      end
      kern_mem[0] = 24'd1;
      kern_mem[4] = 24'd7;
      kern_mem[8] = 24'd2;
      cfg(0, 4, 1, 1, 1, 0, 1, 1, 1);
      push(0, 1);
      push(1, 3);
      push(2, 4);
      push(3, 2);
      push(4, 6);
      push(5, 8);
      run(-1);

      for (int i = 0; i < 64; i++) begin
         img_mem[i]  = {16'd0, 8'(i)};
         kern_mem[i] = 24'd1;
      end
      cfg(1, 2, 0, 2, 0, 1, 0, 1, 1);
      push(0, 0);
      push(1, 2);
      push(2, 4);
      addr_q.delete();
      rec_addr = 1'b1;
      run(15);
      rec_addr = 1'b0;
      chk("stride_addr_count", addr_q.size(), 6);
      for (int i = 0; i < 6; i++) begin
         if (i < addr_q.size()) chk("stride_img_addr", addr_q[i], i);
      end

      abort_prep();
      soft_rst = 1'b1;
      @(posedge clk);
      #1;
      soft_rst = 1'b0;
      abort_after();
      t1_full();

      abort_prep();
      rst_n = 1'b0;
      #1;
      abort_after();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      t1_full();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
